// File: rtl/dcache_bus_pkg.sv
// dcache_mem_bridge shared types: FSM state encoding, line geometry and counter widths.
// Imported by the bridge top, its line assembler and the memory-bus interface.
package dcache_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DONE,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } state_e;

    localparam int LINE_WORDS = 4;
    localparam int WORD_OFF_W = 2;
    localparam int LINE_OFF_W = 4;
    localparam int WORD_BITS  = 32;
    localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

endpackage

// File: rtl/dcache_mem_bridge_if.sv
// Single-port pipelined word bus between the bridge (master) and memory (slave).
// Ports: mem_req/mem_we/mem_addr/mem_wdata out of master; mem_gnt/mem_rvalid/mem_rdata in.
interface dcache_mem_bridge_if;
    import dcache_bus_pkg::*;

    logic                 mem_req;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [WORD_BITS-1:0] mem_wdata;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [WORD_BITS-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/dcache_line_asm.sv
// Word-indexed 128-bit line register that collects returned read words.
// Ports: clk, rst (sync, high), we, idx[1:0], wdata[31:0] in; line[127:0] out.
module dcache_line_asm
    import dcache_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [WORD_OFF_W-1:0] idx,
    input  logic [WORD_BITS-1:0]  wdata,
    output logic [LINE_BITS-1:0]  line
);

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (we) begin
            line[{idx, 5'd0} +: WORD_BITS] <= wdata;
        end
    end

endmodule

// File: rtl/dcache_mem_bridge.sv
// dcache line refill / write-back responder: one 128-bit line <-> four 32-bit bus words.
// Ports: clk, rst; cpu read (cpu_ren/cpu_raddr -> dev_rrdy/ren_received/dev_rvalid/dev_rdata);
// cpu write (cpu_wen/cpu_waddr/cpu_wdata -> dev_wrdy/write_finish); mem (master modport).
// Optional: DCACHE_BRIDGE_CRITICAL_WORD_FIRST_EN starts reads at cpu_raddr[3:2], wrapping.
module dcache_mem_bridge
    import dcache_bus_pkg::*;
#(
    parameter int MAX_RD_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ren,
    input  logic [31:0]            cpu_raddr,
    output logic                   dev_rrdy,
    output logic                   ren_received,
    output logic                   dev_rvalid,
    output logic [LINE_BITS-1:0]   dev_rdata,
    input  logic [3:0]             cpu_wen,
    input  logic [31:0]            cpu_waddr,
    input  logic [LINE_BITS-1:0]   cpu_wdata,
    output logic                   dev_wrdy,
    output logic                   write_finish,
    dcache_mem_bridge_if.master    mem
);

    state_e state_q, state_d;

    logic [31-LINE_OFF_W:0] line_q;
    logic [LINE_BITS-1:0]   wbuf_q;
    logic [CNT_W-1:0]       wcnt_q, icnt_q, rcnt_q;
    logic [CNT_W-1:0]       rd_inflight;
    logic [WORD_OFF_W-1:0]  start, rd_idx, ret_idx;
    logic acc_wr, acc_rd, wr_gnt, rd_gnt, rd_ret, rd_full;
    logic unused_bits;

    // Only the line-address part of the request addresses is consumed here.
    assign unused_bits = ^{cpu_raddr[LINE_OFF_W-1:0], cpu_waddr[LINE_OFF_W-1:0]};

    // Counters are 3 bits so the in-flight difference can reach 4 without wrapping.
    assign rd_inflight = icnt_q - rcnt_q;
    assign rd_full     = (rd_inflight == CNT_W'(MAX_RD_OUTSTANDING));
    assign rd_idx      = start + icnt_q[WORD_OFF_W-1:0];
    assign ret_idx     = start + rcnt_q[WORD_OFF_W-1:0];

    assign dev_rrdy = (state_q == IDLE);
    assign dev_wrdy = (state_q == IDLE);

`ifdef DCACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
    logic [WORD_OFF_W-1:0] start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
        end else if (acc_rd) begin
            start_q <= cpu_raddr[LINE_OFF_W-1:2];
        end
    end

    assign start = start_q;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_wr        = 1'b0;
        acc_rd        = 1'b0;
        wr_gnt        = 1'b0;
        rd_gnt        = 1'b0;
        rd_ret        = 1'b0;
        ren_received  = 1'b0;
        dev_rvalid    = 1'b0;
        write_finish  = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                // Write wins a tie so write-back is ordered before refill.
                if (|cpu_wen) begin
                    acc_wr  = 1'b1;
                    state_d = WR_REQ;
                end else if (cpu_ren) begin
                    acc_rd       = 1'b1;
                    ren_received = 1'b1;
                    state_d      = RD_REQ;
                end
            end
            WR_REQ: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {line_q, wcnt_q[WORD_OFF_W-1:0], 2'b00};
                mem.mem_wdata = wbuf_q[{wcnt_q[WORD_OFF_W-1:0], 5'd0} +: WORD_BITS];
                wr_gnt        = mem.mem_gnt;
                if (wr_gnt && wcnt_q == LAST_WORD) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                write_finish = 1'b1;
                state_d      = IDLE;
            end
            RD_REQ: begin
                mem.mem_req  = !rd_full;
                mem.mem_addr = {line_q, rd_idx, 2'b00};
                rd_gnt       = !rd_full && mem.mem_gnt;
                rd_ret       = mem.mem_rvalid;
                if (rd_ret && rcnt_q == LAST_WORD) begin
                    state_d = RD_DONE;
                end else if (rd_gnt && icnt_q == LAST_WORD) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rd_ret = mem.mem_rvalid;
                if (rd_ret && rcnt_q == LAST_WORD) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                dev_rvalid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            wbuf_q <= '0;
            wcnt_q <= '0;
            icnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (acc_wr) begin
                line_q <= cpu_waddr[31:LINE_OFF_W];
                wbuf_q <= cpu_wdata;
                wcnt_q <= '0;
            end else if (acc_rd) begin
                line_q <= cpu_raddr[31:LINE_OFF_W];
                icnt_q <= '0;
                rcnt_q <= '0;
            end
            if (wr_gnt) wcnt_q <= wcnt_q + 3'd1;
            if (rd_gnt) icnt_q <= icnt_q + 3'd1;
            if (rd_ret) rcnt_q <= rcnt_q + 3'd1;
        end
    end

    dcache_line_asm u_line (
        .clk   (clk),
        .rst   (rst),
        .we    (rd_ret),
        .idx   (ret_idx),
        .wdata (mem.mem_rdata),
        .line  (dev_rdata)
    );

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge: instance 0 uses 4 outstanding reads, instance 1 uses 1.
// A small memory model per instance applies grant stalls and read-return delay.
module tb_dcache_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         cpu_ren      [2];
    logic [31:0]  cpu_raddr    [2];
    logic [3:0]   cpu_wen      [2];
    logic [31:0]  cpu_waddr    [2];
    logic [127:0] cpu_wdata    [2];
    logic         dev_rrdy     [2];
    logic         ren_received [2];
    logic         dev_rvalid   [2];
    logic [127:0] dev_rdata    [2];
    logic         dev_wrdy     [2];
    logic         write_finish [2];

    logic         mreq [2];
    logic         mwe  [2];
    logic [31:0]  maddr[2];
    logic [31:0]  mwd  [2];
    logic         mgnt [2];
    logic         mrv  [2];
    logic [31:0]  mrd  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dcache_mem_bridge_if bus ();
        dcache_mem_bridge #(.MAX_RD_OUTSTANDING((g == 0) ? 4 : 1)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .cpu_ren      (cpu_ren[g]),
            .cpu_raddr    (cpu_raddr[g]),
            .dev_rrdy     (dev_rrdy[g]),
            .ren_received (ren_received[g]),
            .dev_rvalid   (dev_rvalid[g]),
            .dev_rdata    (dev_rdata[g]),
            .cpu_wen      (cpu_wen[g]),
            .cpu_waddr    (cpu_waddr[g]),
            .cpu_wdata    (cpu_wdata[g]),
            .dev_wrdy     (dev_wrdy[g]),
            .write_finish (write_finish[g]),
            .mem          (bus)
        );
        assign mreq[g]        = bus.mem_req;
        assign mwe[g]         = bus.mem_we;
        assign maddr[g]       = bus.mem_addr;
        assign mwd[g]         = bus.mem_wdata;
        assign bus.mem_gnt    = mgnt[g];
        assign bus.mem_rvalid = mrv[g];
        assign bus.mem_rdata  = mrd[g];
    end

    // memory model + monitors
    int          stall [2];
    int          dly   [2];
    int          wc    [2];
    int          cyc = 0;
    int          pq_due[2][8];
    logic [31:0] pq_dat[2][8];
    logic [2:0]  ph[2], pt[2];
    logic        rd_fire[2], front_rdy[2];
    logic [31:0] nd[2];
    logic        lg_we  [2][64];
    logic [31:0] lg_addr[2][64];
    logic [31:0] lg_wd  [2][64];
    int lg_n[2], rr_cnt[2], rv_cnt[2], wf_cnt[2], ret_cnt[2];
    int rr_cyc[2], rv_cyc[2], wf_cyc[2], out_n[2], out_max[2];

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mgnt[g]      = mreq[g] && (wc[g] >= stall[g]);
            rd_fire[g]   = mreq[g] && mgnt[g] && !mwe[g];
            front_rdy[g] = (ph[g] != pt[g]) && (pq_due[g][ph[g]] == cyc + 1);
            nd[g]        = 32'hA0 + {30'd0, maddr[g][3:2]};
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                wc[g]      <= 0;
                ph[g]      <= '0;
                pt[g]      <= '0;
                mrv[g]     <= 1'b0;
                mrd[g]     <= '0;
                out_n[g]   <= 0;
                out_max[g] <= 0;
            end else begin
                if (mreq[g] && mgnt[g]) begin
                    wc[g]                <= 0;
                    lg_we[g][lg_n[g]]    <= mwe[g];
                    lg_addr[g][lg_n[g]]  <= maddr[g];
                    lg_wd[g][lg_n[g]]    <= mwd[g];
                    lg_n[g]              <= lg_n[g] + 1;
                end else if (mreq[g]) begin
                    wc[g] <= wc[g] + 1;
                end
                if (front_rdy[g]) begin
                    mrv[g] <= 1'b1;
                    mrd[g] <= pq_dat[g][ph[g]];
                    ph[g]  <= ph[g] + 3'd1;
                end else if (rd_fire[g] && dly[g] == 1) begin
                    mrv[g] <= 1'b1;
                    mrd[g] <= nd[g];
                end else begin
                    mrv[g] <= 1'b0;
                end
                if (rd_fire[g] && dly[g] != 1) begin
                    pq_due[g][pt[g]] <= cyc + dly[g];
                    pq_dat[g][pt[g]] <= nd[g];
                    pt[g]            <= pt[g] + 3'd1;
                end
                out_n[g]   <= out_n[g] + (rd_fire[g] ? 1 : 0) - (mrv[g] ? 1 : 0);
                out_max[g] <= (out_n[g] > out_max[g]) ? out_n[g] : out_max[g];
                if (ren_received[g]) begin
                    rr_cnt[g] <= rr_cnt[g] + 1;
                    rr_cyc[g] <= cyc;
                end
                if (dev_rvalid[g]) begin
                    rv_cnt[g] <= rv_cnt[g] + 1;
                    rv_cyc[g] <= cyc;
                end
                if (write_finish[g]) begin
                    wf_cnt[g] <= wf_cnt[g] + 1;
                    wf_cyc[g] <= cyc;
                end
                if (mrv[g]) ret_cnt[g] <= ret_cnt[g] + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int g, input int idx,
                           input logic we, input logic [31:0] addr);
        chk(tag, {95'd0, lg_we[g][idx], lg_addr[g][idx]}, {95'd0, we, addr});
    endtask

    task automatic wait_rv(input int g, input int bound);
        for (int i = 0; i < bound && !dev_rvalid[g]; i++) @(negedge clk);
        chk("rvalid_seen", {127'd0, dev_rvalid[g]}, 128'd1);
    endtask

    localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;

    initial begin
        int base, t0, n0, r0, hi, cw;
        for (int g = 0; g < 2; g++) begin
            cpu_ren[g]   = 1'b0;
            cpu_raddr[g] = '0;
            cpu_wen[g]   = '0;
            cpu_waddr[g] = '0;
            cpu_wdata[g] = '0;
            stall[g]     = 0;
            dly[g]       = 1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy", {126'd0, dev_rrdy[0], dev_wrdy[0]}, 128'd3);
        chk("rst_pulses", {125'd0, ren_received[0], dev_rvalid[0], write_finish[0]}, 128'd0);
        chk("rst_rdata", dev_rdata[0], 128'd0);
        chk("rst_bus", {62'd0, mreq[0], mwe[0], maddr[0], mwd[0]}, 128'd0);

        // 1: read, zero-wait memory
        @(negedge clk);
        base = lg_n[0];
        cpu_ren[0]   = 1'b1;
        cpu_raddr[0] = 32'h1C000040;
        #1 t0 = cyc;
        chk("rd_ren_received", {127'd0, ren_received[0]}, 128'd1);
        @(negedge clk);
        cpu_ren[0] = 1'b0;
        wait_rv(0, 20);
        chk("rd_latency", 128'(cyc - t0), 128'd6);
        chk("rd_line", dev_rdata[0], LINE_A);
        @(negedge clk);
        chk("rd_pulse_idle", {126'd0, dev_rvalid[0], dev_rrdy[0]}, 128'd1);
        chk("rd_hold", dev_rdata[0], LINE_A);
        chk("rd_nreq", 128'(lg_n[0] - base), 128'd4);
        for (int i = 0; i < 4; i++)
            chk_log("rd_addr", 0, base + i, 1'b0, 32'h1C000040 + 32'(4 * i));

        // 2: write, grant stalled 2 cycles per word
        stall[0] = 2;
        base = lg_n[0];
        n0 = wf_cnt[0];
        cpu_wen[0]   = 4'hF;
        cpu_waddr[0] = 32'h00000080;
        cpu_wdata[0] = 128'h44444444_33333333_22222222_11111111;
        #1 t0 = cyc;
        @(negedge clk);
        cpu_wen[0] = '0;
        hi = 0;
        for (int i = 0; i < 40 && !write_finish[0]; i++) begin
            if (dev_wrdy[0]) hi++;
            @(negedge clk);
        end
        chk("wr_finish_seen", {127'd0, write_finish[0]}, 128'd1);
        chk("wr_latency", 128'(cyc - t0), 128'd13);
        chk("wr_wrdy_low", 128'(hi), 128'd0);
        @(negedge clk);
        chk("wr_pulse_idle", {126'd0, write_finish[0], dev_wrdy[0]}, 128'd1);
        chk("wr_one_pulse", 128'(wf_cnt[0] - n0), 128'd1);
        chk("wr_nreq", 128'(lg_n[0] - base), 128'd4);
        for (int i = 0; i < 4; i++) begin
            chk_log("wr_addr", 0, base + i, 1'b1, 32'h80 + 32'(4 * i));
            chk("wr_data", {96'd0, lg_wd[0][base + i]}, {96'd0, 32'h11111111 * 32'(i + 1)});
        end
        stall[0] = 0;

        // 3: write and read together, write first
        base = lg_n[0];
        n0 = rr_cnt[0];
        cpu_wen[0]   = 4'b0010;
        cpu_waddr[0] = 32'h00000100;
        cpu_wdata[0] = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
        cpu_ren[0]   = 1'b1;
        cpu_raddr[0] = 32'h00000200;
        #1 t0 = cyc;
        chk("col_ren_blocked", {127'd0, ren_received[0]}, 128'd0);
        @(negedge clk);
        cpu_wen[0] = '0;
        for (int i = 0; i < 30 && rr_cnt[0] == n0; i++) @(negedge clk);
        cpu_ren[0] = 1'b0;
        chk("col_ren_seen", 128'(rr_cnt[0] - n0), 128'd1);
        chk("col_ren_cycle", 128'(rr_cyc[0] - t0), 128'd6);
        chk("col_after_wf", 128'(rr_cyc[0] - wf_cyc[0]), 128'd1);
        wait_rv(0, 20);
        chk("col_line", dev_rdata[0], LINE_A);
        chk("col_nreq", 128'(lg_n[0] - base), 128'd8);
        for (int i = 0; i < 4; i++) begin
            chk_log("col_wr", 0, base + i, 1'b1, 32'h100 + 32'(4 * i));
            chk_log("col_rd", 0, base + 4 + i, 1'b0, 32'h200 + 32'(4 * i));
        end

        // 4: one outstanding read, rvalid delayed 3 extra cycles
        @(negedge clk);
        dly[1] = 4;
        base = lg_n[1];
        cpu_ren[1]   = 1'b1;
        cpu_raddr[1] = 32'h00000300;
        #1 t0 = cyc;
        @(negedge clk);
        cpu_ren[1] = 1'b0;
        wait_rv(1, 60);
        chk("mo1_latency", 128'(cyc - t0), 128'd21);
        chk("mo1_line", dev_rdata[1], LINE_A);
        chk("mo1_max_out", 128'(out_max[1]), 128'd1);
        chk("mo1_nreq", 128'(lg_n[1] - base), 128'd4);
        for (int i = 0; i < 4; i++)
            chk_log("mo1_addr", 1, base + i, 1'b0, 32'h300 + 32'(4 * i));

        // 5: reset during RD_WAIT after two returns
        @(negedge clk);
        dly[0] = 4;
        n0 = rv_cnt[0];
        r0 = ret_cnt[0];
        cpu_ren[0]   = 1'b1;
        cpu_raddr[0] = 32'h00000400;
        @(negedge clk);
        cpu_ren[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_returns", 128'(ret_cnt[0] - r0), 128'd2);
        chk("mid_busy", {127'd0, dev_rrdy[0]}, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", {126'd0, dev_rrdy[0], dev_wrdy[0]}, 128'd3);
        chk("mid_rst_pulses", {125'd0, ren_received[0], dev_rvalid[0], write_finish[0]}, 128'd0);
        chk("mid_rst_rdata", dev_rdata[0], 128'd0);
        chk("mid_rst_bus", {62'd0, mreq[0], mwe[0], maddr[0], mwd[0]}, 128'd0);
        rst = 1'b0;
        dly[0] = 1;
        repeat (10) @(negedge clk);
        chk("mid_no_rvalid", 128'(rv_cnt[0] - n0), 128'd0);

        // 6: read starting mid-line
`ifdef DCACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
        cw = 2;
`else
        cw = 0;
`endif
        base = lg_n[0];
        cpu_ren[0]   = 1'b1;
        cpu_raddr[0] = 32'h00002008;
        #1 t0 = cyc;
        @(negedge clk);
        cpu_ren[0] = 1'b0;
        wait_rv(0, 20);
        chk("cw_latency", 128'(cyc - t0), 128'd6);
        chk("cw_line", dev_rdata[0], LINE_A);
        for (int i = 0; i < 4; i++)
            chk_log("cw_order", 0, base + i, 1'b0, 32'h2000 + 32'(4 * ((cw + i) % 4)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dcache_mem_bridge.md
Name: dcache_mem_bridge

Overview:
- Responder end of the dcache line-refill/write-back protocol.
- Accepts one 128-bit line read (cpu_ren/cpu_raddr) or one 128-bit line write (cpu_wen/cpu_waddr/cpu_wdata) at a time.
- Converts each into four 32-bit word transactions on a single-port pipelined memory bus. Returns the assembled line (dev_rvalid/dev_rdata) or signals write completion (write_finish).
- Sits between the dcache and the memory/interconnect port. The uncached path is served elsewhere.

Parameters:
- LINE_WORDS, 4, words per line; fixed, not overridable.
- MAX_RD_OUTSTANDING, 4, read words issued but not yet returned (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cpu_ren  in  1  line read request; held until ren_received.
- cpu_raddr  in  32  line read address; bits [3:0] ignored except by the optional feature.
- dev_rrdy  out  1  bridge can accept a read.
- ren_received  out  1  one-cycle pulse: read latched.
- dev_rvalid  out  1  one-cycle pulse: line ready.
- dev_rdata  out  128  assembled line; word i in [32i+31:32i].
- cpu_wen  in  4  line write strobe; any bit set = request (one-cycle pulse).
- cpu_waddr  in  32  line write address; bits [3:0] ignored.
- cpu_wdata  in  128  line write data.
- dev_wrdy  out  1  bridge can accept a write.
- write_finish  out  1  one-cycle pulse: all 4 words granted.
- mem_req  out  1  word request valid.
- mem_we  out  1  1 = write word.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_wdata  out  32  write word.
- mem_gnt  in  1  request accepted this cycle (req & gnt).
- mem_rvalid  in  1  read word returned, in issue order.
- mem_rdata  in  32  returned word.

Behaviour:
- States: IDLE, WR_REQ, WR_DONE, RD_REQ, RD_WAIT, RD_DONE.
- dev_rrdy = dev_wrdy = (state == IDLE).
- Reset values: state IDLE; all outputs 0; dev_rdata 0; counters 0.
- Accept rules in IDLE:
  - If |cpu_wen, latch the line address ({cpu_waddr[31:4],4'b0}) and cpu_wdata, then go to WR_REQ.
  - Else if cpu_ren, latch the line address, pulse ren_received in the same cycle, then go to RD_REQ.
  - If both arrive together, the write wins. cpu_ren stays held by the cache and is accepted on the next IDLE. This keeps write-back ordered before refill.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr = line | (wcnt<<2), mem_wdata = latched word wcnt.
  - wcnt increments on mem_gnt. After the 4th grant, go to WR_DONE.
  - WR_DONE: write_finish=1 for one cycle, then IDLE.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr = line | (icnt<<2).
  - icnt increments on mem_gnt.
  - mem_req is forced 0 while (icnt − rcnt) == MAX_RD_OUTSTANDING.
  - After the 4th grant, go to RD_WAIT (or straight to RD_DONE if the 4th return arrives in the same cycle).
- Data returns (RD_REQ or RD_WAIT): on mem_rvalid, write mem_rdata into dev_rdata word slot rcnt's target index, then rcnt++. The 4th return moves to RD_DONE.
- RD_DONE: dev_rvalid=1 for one cycle, then IDLE.
- dev_rdata holds its value until the next read overwrites it.
- Counters are 3 bits and clear on entry to RD_REQ/WR_REQ.
- mem_rvalid outside RD_REQ/RD_WAIT is ignored.
- A grant and a return in the same cycle both take effect.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle), request accepted at T:
  - Read: dev_rvalid at T+6; IDLE at T+7.
  - Write: write_finish at T+5; IDLE at T+6.
- Reset mid-transaction aborts it and returns to IDLE. No completion pulse is emitted. The memory side is reset together, so no stale returns arrive.

Optional Feature:
- Macro: DCACHE_BRIDGE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - A read starts at word s = cpu_raddr[3:2] latched at accept.
  - Issue order is (s+k) mod 4, wrapping within the line.
  - Return k is placed at word index (s+k) mod 4.
- Undefined: s = 0 always; cpu_raddr[3:2] ignored.
- Writes always start at word 0.

Decomposition:
- Package dcache_bus_pkg: state encodings, LINE_WORDS, word-offset width (2), line-offset width (4).
- One sub-module, dcache_line_asm: 128-bit word-indexed register with write enable, 2-bit index and 32-bit data; holds dev_rdata.

Test Plan:
- Read 0x1C000040, zero-wait memory returning 0xA0..0xA3 → mem_addr 0x40,0x44,0x48,0x4C; ren_received at T; dev_rvalid at T+6; dev_rdata=0x000000A3_000000A2_000000A1_000000A0.
- Write 0x00000080 with cpu_wdata=0x44444444_33333333_22222222_11111111, gnt stalled 2 cycles per word → words at 0x80..0x8C in order; write_finish single pulse; dev_wrdy low throughout.
- cpu_wen and cpu_ren in the same IDLE cycle → 4 writes complete first, then ren_received, then 4 reads; no overlap on mem_req.
- MAX_RD_OUTSTANDING=1, rvalid delayed 3 cycles → never more than 1 unreturned request; line still assembled correctly.
- rst asserted during RD_WAIT after 2 returns → next cycle: all outputs 0, dev_rrdy=1, no dev_rvalid.
- With macro defined, read 0x2008 → issue order 0x2008,0x200C,0x2000,0x2004; dev_rdata words placed at their true indices.
